picorv32_mem_ctrl: RTL and testbench

Parametrised memory and MMIO responder for the picorv32 native memory interface. It replaces the fixed 256-word zero-wait-state memory in the core's top level, and adds:
- configurable depth and read/write wait states;
- a small MMIO window with a GPIO register, a free-running cycle counter and a bus-error status register;
- a defined response to out-of-range accesses.

It sits directly on the core's `mem_*` bus.

---
 rtl/picorv32_mem_ctrl.sv | 178 +++++++++++++++++
 tb/tb_picorv32_mem_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/picorv32_mem_ctrl.sv
// Memory and MMIO responder for the picorv32 native mem_* bus: RAM with
// configurable wait states, plus GPIO, cycle counter and bus-error registers.
`timescale 1ns/1ps

module picorv32_mem_ctrl #(
    parameter int          MEM_WORDS   = 256,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] MMIO_BASE   = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic [31:0] gpio_out,
    output logic        bus_err
);

    localparam int          AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [32:0] RAM_BYTES = 33'(MEM_WORDS) << 2;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state_reg;
    logic [3:0]  wait_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  wstrb_reg;
    logic        ready_reg;
    logic        sel_ram_reg;
    logic [31:0] mmio_rdata_reg;
    logic [31:0] gpio_reg;
    logic [31:0] cycle_reg;
    logic        err_reg;

    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [3:0]  cur_wstrb;
    logic        commit;
    logic        cur_is_ram;
    logic        cur_is_mmio;
    logic [AW-1:0] ram_idx;
    logic        ram_access;
    logic [31:0] ram_q;
    logic [31:0] mmio_rd;
    logic        unused_bits;

    // With zero wait states the commit edge is also the accept edge, so the
    // live bus must be used before it has been latched.
    always_comb begin
        cur_addr  = addr_reg;
        cur_wdata = wdata_reg;
        cur_wstrb = wstrb_reg;
        if (state_reg == ST_IDLE) begin
            cur_addr  = mem_addr;
            cur_wdata = mem_wdata;
            cur_wstrb = mem_wstrb;
        end
    end

    assign commit = resetn &&
                    ((state_reg == ST_IDLE && mem_valid && (WAIT_STATES == 0)) ||
                     (state_reg == ST_WAIT && wait_reg == 4'd0));

    assign cur_is_ram  = ({1'b0, cur_addr} < RAM_BYTES);
    assign cur_is_mmio = !cur_is_ram && (cur_addr[31:4] == MMIO_BASE[31:4]);
    assign ram_idx     = cur_addr[AW+1:2];
    assign ram_access  = commit && cur_is_ram;
    assign unused_bits = &{1'b0, mem_instr, cur_addr[1:0]};

    always_comb begin
        mmio_rd = 32'd0;
        if (cur_is_mmio) begin
            case (cur_addr[3:2])
                2'd0:    mmio_rd = gpio_reg;
                2'd1:    mmio_rd = cycle_reg;
                2'd2:    mmio_rd = {31'd0, err_reg};
                default: mmio_rd = 32'd0;
            endcase
        end
    end

    // One byte-wide array per lane keeps each lane a plain single-port RAM.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_mem [MEM_WORDS];
        logic [7:0] lane_q;

        always_ff @(posedge clk) begin
            if (ram_access) begin
                lane_q <= lane_mem[ram_idx];
                if (cur_wstrb[gi]) begin
                    lane_mem[ram_idx] <= cur_wdata[8*gi +: 8];
                end
            end
        end

        assign ram_q[8*gi +: 8] = lane_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= ST_IDLE;
            wait_reg       <= 4'd0;
            addr_reg       <= 32'd0;
            wdata_reg      <= 32'd0;
            wstrb_reg      <= 4'd0;
            ready_reg      <= 1'b0;
            sel_ram_reg    <= 1'b0;
            mmio_rdata_reg <= 32'd0;
            gpio_reg       <= 32'd0;
            cycle_reg      <= 32'd0;
            err_reg        <= 1'b0;
        end else begin
            cycle_reg <= cycle_reg + 32'd1;
            ready_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (mem_valid) begin
                        addr_reg  <= mem_addr;
                        wdata_reg <= mem_wdata;
                        wstrb_reg <= mem_wstrb;
                        if (WAIT_STATES == 0) begin
                            state_reg <= ST_RESP;
                            ready_reg <= 1'b1;
                        end else begin
                            wait_reg  <= WAIT_LOAD;
                            state_reg <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_reg == 4'd0) begin
                        state_reg <= ST_RESP;
                        ready_reg <= 1'b1;
                    end else begin
                        wait_reg <= wait_reg - 4'd1;
                    end
                end
                ST_RESP: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase

            if (commit) begin
                sel_ram_reg    <= cur_is_ram;
                mmio_rdata_reg <= mmio_rd;
                if (cur_is_mmio && cur_addr[3:2] == 2'd0) begin
                    for (int i = 0; i < 4; i++) begin
                        if (cur_wstrb[i]) begin
                            gpio_reg[8*i +: 8] <= cur_wdata[8*i +: 8];
                        end
                    end
                end
                // Out-of-range set wins over an ERR-register clear.
                if (!cur_is_ram && !cur_is_mmio) begin
                    err_reg <= 1'b1;
                end else if (cur_is_mmio && cur_addr[3:2] == 2'd2 && |cur_wstrb) begin
                    err_reg <= 1'b0;
                end
            end
        end
    end

    assign mem_ready = ready_reg;
    assign mem_rdata = sel_ram_reg ? ram_q : mmio_rdata_reg;
    assign gpio_out  = gpio_reg;
    assign bus_err   = err_reg;

endmodule

// File: tb/tb_picorv32_mem_ctrl.sv
// Scoreboard bench for picorv32_mem_ctrl: three instances with 0, 3 and 5
// wait states share one clock and reset.
`timescale 1ns/1ps

module tb_picorv32_mem_ctrl;

    localparam logic [31:0] MB = 32'h1000_0000;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        bit          chk;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        mem_valid [3];
    logic        mem_instr [3];
    logic [31:0] mem_addr  [3];
    logic [31:0] mem_wdata [3];
    logic [3:0]  mem_wstrb [3];
    logic        mem_ready [3];
    logic [31:0] mem_rdata [3];
    logic [31:0] gpio_out  [3];
    logic        bus_err   [3];

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] tb_cyc;
    logic [31:0] last_rdy;

    always #5 clk = ~clk;

    // Reference cycle count: starts at 0 in reset, +1 per clock afterwards.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) tb_cyc <= 32'd0;
        else         tb_cyc <= tb_cyc + 32'd1;
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        picorv32_mem_ctrl #(
            .MEM_WORDS  (256),
            .WAIT_STATES(gi == 0 ? 0 : (gi == 1 ? 3 : 5)),
            .MMIO_BASE  (MB)
        ) u_dut (
            .clk      (clk),
            .resetn   (resetn),
            .mem_valid(mem_valid[gi]),
            .mem_instr(mem_instr[gi]),
            .mem_addr (mem_addr[gi]),
            .mem_wdata(mem_wdata[gi]),
            .mem_wstrb(mem_wstrb[gi]),
            .mem_ready(mem_ready[gi]),
            .mem_rdata(mem_rdata[gi]),
            .gpio_out (gpio_out[gi]),
            .bus_err  (bus_err[gi])
        );
    end

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 3 : 5);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after a later rising edge.
    task automatic xact(input int d, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic [31:0] exp_rdata,
                        input bit chk, input string tag, output logic [31:0] got);
        exp_t e;
        int   lat;
        e.tag = tag; e.rdata = exp_rdata; e.chk = chk;
        sb_q.push_back(e);
        mem_valid[d] = 1'b1; mem_instr[d] = 1'b0;
        mem_addr[d] = addr; mem_wdata[d] = wdata; mem_wstrb[d] = wstrb;
        @(posedge clk); #1;
        lat = 0;
        for (int i = 0; i < 40 && !mem_ready[d]; i++) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb_q.pop_front();
        got = mem_rdata[d];
        last_rdy = tb_cyc;
        check_val({e.tag, "_ready"}, 32'(mem_ready[d]), 32'd1);
        // Edges after the accepting edge until mem_ready is visible.
        check_val({e.tag, "_lat"}, 32'(lat), 32'(ws_of(d)));
        if (e.chk) check_val({e.tag, "_rdata"}, got, e.rdata);
        $display("[%0t] dut%0d %s addr=%h wdata=%h wstrb=%h rdata=%h lat=%0d",
                 $time, d, e.tag, addr, wdata, wstrb, got, lat);
        mem_valid[d] = 1'b0; mem_wstrb[d] = 4'h0;
        @(posedge clk); #1;
        check_val({e.tag, "_pulse"}, 32'(mem_ready[d]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r, a, b, exp_c;
        logic [31:0] t1;
        int pulses;
        for (int d = 0; d < 3; d++) begin
            mem_valid[d] = 1'b0; mem_instr[d] = 1'b0;
            mem_addr[d] = 32'd0; mem_wdata[d] = 32'd0; mem_wstrb[d] = 4'h0;
        end
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        for (int d = 0; d < 3; d++) begin
            check_val($sformatf("rst_ready%0d", d), 32'(mem_ready[d]), 32'd0);
            check_val($sformatf("rst_rdata%0d", d), mem_rdata[d], 32'd0);
            check_val($sformatf("rst_gpio%0d", d), gpio_out[d], 32'd0);
            check_val($sformatf("rst_err%0d", d), 32'(bus_err[d]), 32'd0);
        end

        // Zero wait states: RAM writes, byte strobes, pre-write read data.
        xact(0, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'd0, 0, "w10", r);
        xact(0, 32'h10, 32'd0, 4'h0, 32'hDEAD_BEEF, 1, "r10", r);
        xact(0, 32'h10, 32'h0000_5500, 4'b0010, 32'hDEAD_BEEF, 1, "w10_lane1", r);
        xact(0, 32'h10, 32'd0, 4'h0, 32'hDEAD_55EF, 1, "r10_b", r);
        xact(0, 32'h0, 32'hCAFE_F00D, 4'hF, 32'd0, 0, "w0", r);

        // Out of range.
        xact(0, 32'h400, 32'd0, 4'h0, 32'd0, 1, "r400", r);
        check_val("err_set", 32'(bus_err[0]), 32'd1);
        xact(0, 32'h400, 32'hBAD0_BAD0, 4'hF, 32'd0, 1, "w400", r);
        xact(0, 32'h0, 32'd0, 4'h0, 32'hCAFE_F00D, 1, "r0_unchanged", r);
        xact(0, MB + 32'hC, 32'd0, 4'h0, 32'd0, 1, "r_rsvd", r);
        check_val("err_after_rsvd", 32'(bus_err[0]), 32'd1);
        xact(0, MB + 32'h8, 32'd0, 4'h0, 32'd1, 1, "r_err1", r);
        xact(0, MB + 32'h8, 32'd0, 4'b0001, 32'd1, 1, "w_err", r);
        check_val("err_clear", 32'(bus_err[0]), 32'd0);
        xact(0, MB + 32'h8, 32'd0, 4'h0, 32'd0, 1, "r_err0", r);

        // GPIO.
        xact(0, MB, 32'hA5A5_0F0F, 4'hF, 32'd0, 1, "w_gpio", r);
        check_val("gpio_full", gpio_out[0], 32'hA5A5_0F0F);
        xact(0, MB, 32'hFF00_0000, 4'b1000, 32'hA5A5_0F0F, 1, "w_gpio_b3", r);
        check_val("gpio_byte", gpio_out[0], 32'hFFA5_0F0F);
        xact(0, MB, 32'd0, 4'h0, 32'hFFA5_0F0F, 1, "r_gpio", r);

        // Cycle counter: value at the commit edge before increment.
        exp_c = tb_cyc;
        xact(0, MB + 32'h4, 32'd0, 4'h0, exp_c, 1, "r_cyc_a", a);
        exp_c = tb_cyc;
        xact(0, MB + 32'h4, 32'd0, 4'h0, exp_c, 1, "r_cyc_b", b);
        check_val("cyc_delta", b - a, 32'd2);
        exp_c = tb_cyc;
        xact(0, MB + 32'h4, 32'hFFFF_FFFF, 4'hF, exp_c, 1, "w_cyc", r);
        exp_c = tb_cyc;
        xact(0, MB + 32'h4, 32'd0, 4'h0, exp_c, 1, "r_cyc_c", r);
        xact(0, MB + 32'h10, 32'd0, 4'h0, 32'd0, 1, "r_past_mmio", r);
        check_val("err_past_mmio", 32'(bus_err[0]), 32'd1);

        // Three wait states: latency and back-to-back spacing.
        xact(1, 32'h4, 32'h0BAD_F00D, 4'hF, 32'd0, 0, "ws3_w4", r);
        t1 = last_rdy;
        xact(1, 32'h4, 32'd0, 4'h0, 32'h0BAD_F00D, 1, "ws3_r4", r);
        check_val("ws3_spacing", last_rdy - t1, 32'd5);
        exp_c = tb_cyc + 32'd3;
        xact(1, MB + 32'h4, 32'd0, 4'h0, exp_c, 1, "ws3_r_cyc", r);

        // Five wait states: reset during WAIT of a write.
        xact(2, MB, 32'h0000_1234, 4'hF, 32'd0, 0, "ws5_w_gpio", r);
        xact(2, 32'h20, 32'h1111_2222, 4'hF, 32'd0, 0, "ws5_w20", r);
        xact(2, 32'h800, 32'd0, 4'h0, 32'd0, 1, "ws5_r800", r);
        check_val("ws5_err_set", 32'(bus_err[2]), 32'd1);
        mem_valid[2] = 1'b1; mem_addr[2] = 32'h20;
        mem_wdata[2] = 32'h9999_9999; mem_wstrb[2] = 4'hF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("ws5_wait_noready", 32'(mem_ready[2]), 32'd0);
        resetn = 1'b0;
        mem_valid[2] = 1'b0; mem_wstrb[2] = 4'h0;
        #1;
        check_val("mid_rst_ready", 32'(mem_ready[2]), 32'd0);
        check_val("mid_rst_rdata", mem_rdata[2], 32'd0);
        check_val("mid_rst_gpio", gpio_out[2], 32'd0);
        check_val("mid_rst_err", 32'(bus_err[2]), 32'd0);
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        pulses = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (mem_ready[2]) pulses++;
        end
        check_val("mid_rst_no_pulse", 32'(pulses), 32'd0);
        xact(2, 32'h20, 32'd0, 4'h0, 32'h1111_2222, 1, "ws5_r20_kept", r);

        // Counter wrap on the zero-wait instance.
        force g_dut[0].u_dut.cycle_reg = 32'hFFFF_FFFE;
        #1 release g_dut[0].u_dut.cycle_reg;
        xact(0, MB + 32'h4, 32'd0, 4'h0, 32'hFFFF_FFFE, 1, "wrap_a", r);
        xact(0, MB + 32'h4, 32'd0, 4'h0, 32'h0000_0000, 1, "wrap_b", r);

        check_val("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
